// File: rtl/custom_axi_ip_sched.sv
// custom_axi_ip_pkg / custom_axi_ip_sched
//
// Round-robin scheduler that shares one custom_axi_ip datapath among
// NUM_REQ requesters. Jobs are accepted one at a time, the IP is enabled
// until it reports BUSY, and the job then waits for DONE or ERROR. The
// result and an error flag go back to the requester that owns the job. A
// timeout guard ends a job with an error if the IP never completes.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   req_valid_i  per-requester job valid
//   req_data_i   job data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o  one-hot accept strobe (combinational, only in S_IDLE)
//   rsp_valid_o  one-hot response valid to the owning requester
//   rsp_ready_i  per-requester response ready (only the owner's bit counts)
//   rsp_data_o   result, qualified by rsp_valid_o (0 on error)
//   rsp_err_o    1 = IP ERROR or timeout
//   ip_data_o    job data to the IP
//   ip_enable_o  IP enable
//   ip_data_i    result data from the IP
//   ip_status_i  IP status (IDLE/BUSY/DONE/ERROR)
//   grant_id_o   ID of the job in flight (valid while busy_o)
//   busy_o       1 in any state other than S_IDLE
//   err_cnt_o    count of errored jobs, saturating at 8'hFF

package custom_axi_ip_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      ERROR = 2'd3
   } status_e;
endpackage

module custom_axi_ip_sched
   import custom_axi_ip_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16,
   localparam int IDW           = $clog2(NUM_REQ)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic [NUM_REQ-1:0]            rsp_valid_o,
   input  logic [NUM_REQ-1:0]            rsp_ready_i,
   output logic [DATA_WIDTH-1:0]         rsp_data_o,
   output logic                          rsp_err_o,
   output logic [DATA_WIDTH-1:0]         ip_data_o,
   output logic                          ip_enable_o,
   input  logic [DATA_WIDTH-1:0]         ip_data_i,
   input  status_e                       ip_status_i,
   output logic [IDW-1:0]                grant_id_o,
   output logic                          busy_o,
   output logic [7:0]                    err_cnt_o
);

   localparam int          TW     = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned NREQ_U = NUM_REQ;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_RESP
   } state_e;

   state_e                state_q;
   logic [IDW-1:0]        ptr_q;
   logic [TW-1:0]         timer_q;

   logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
   logic                  win_found;
   logic [IDW-1:0]        win_id;
   logic [IDW-1:0]        scan_idx;
   int unsigned           scan_sum;
   logic [NUM_REQ-1:0]    id_onehot;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_data_arr[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Round-robin scan: first valid requester starting at ptr_q, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_idx  = '0;
      scan_sum  = 0;
      for (int unsigned k = 0; k < NREQ_U; k++) begin
         scan_sum = 32'(ptr_q) + k;
         if (scan_sum >= NREQ_U) begin
            scan_sum = scan_sum - NREQ_U;
         end
         scan_idx = IDW'(scan_sum);
         if (!win_found && req_valid_i[scan_idx]) begin
            win_found = 1'b1;
            win_id    = scan_idx;
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      if (state_q == S_IDLE && win_found) begin
         req_ready_o[win_id] = 1'b1;
      end
   end

   always_comb begin
      id_onehot             = '0;
      id_onehot[grant_id_o] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         timer_q     <= '0;
         rsp_valid_o <= '0;
         rsp_data_o  <= '0;
         rsp_err_o   <= 1'b0;
         ip_data_o   <= '0;
         ip_enable_o <= 1'b0;
         grant_id_o  <= '0;
         busy_o      <= 1'b0;
         err_cnt_o   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (win_found) begin
                  state_q     <= S_LAUNCH;
                  ip_data_o   <= req_data_arr[win_id];
                  grant_id_o  <= win_id;
                  timer_q     <= '0;
                  ip_enable_o <= 1'b1;
                  busy_o      <= 1'b1;
               end
            end

            // LAUNCH and WAIT share completion and timeout handling; they
            // differ only in whether enable is still driven.
            S_LAUNCH, S_WAIT: begin
               if (ip_status_i == DONE) begin
                  rsp_data_o  <= ip_data_i;
                  rsp_err_o   <= 1'b0;
                  rsp_valid_o <= id_onehot;
                  ip_enable_o <= 1'b0;
                  state_q     <= S_RESP;
               end else if (ip_status_i == ERROR) begin
                  rsp_data_o  <= '0;
                  rsp_err_o   <= 1'b1;
                  rsp_valid_o <= id_onehot;
                  ip_enable_o <= 1'b0;
                  state_q     <= S_RESP;
               end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  rsp_data_o  <= '0;
                  rsp_err_o   <= 1'b1;
                  rsp_valid_o <= id_onehot;
                  ip_enable_o <= 1'b0;
                  state_q     <= S_RESP;
               end else begin
                  timer_q <= timer_q + TW'(1);
                  if (state_q == S_LAUNCH && ip_status_i == BUSY) begin
                     ip_enable_o <= 1'b0;
                     state_q     <= S_WAIT;
                  end
               end
            end

            S_RESP: begin
               if (rsp_ready_i[grant_id_o]) begin
                  rsp_valid_o <= '0;
                  busy_o      <= 1'b0;
                  state_q     <= S_IDLE;
                  ptr_q       <= (grant_id_o == IDW'(NUM_REQ - 1)) ? '0 : grant_id_o + IDW'(1);
                  if (rsp_err_o && err_cnt_o != 8'hFF) begin
                     err_cnt_o <= err_cnt_o + 8'd1;
                  end
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_custom_axi_ip_sched.sv
// Testbench for custom_axi_ip_sched: table of job vectors, hand-written
// corner sequences (response back-pressure, reset mid-job, counter
// saturation) and randomized jobs checked against a transaction-level model.
module tb_custom_axi_ip_sched;
   import custom_axi_ip_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int DW      = 32;
   localparam int TO      = 16;

   logic                    clk_i = 1'b0;
   logic                    rst_ni = 1'b0;
   logic [NUM_REQ-1:0]      req_valid_i;
   logic [NUM_REQ*DW-1:0]   req_data_i;
   logic [NUM_REQ-1:0]      req_ready_o;
   logic [NUM_REQ-1:0]      rsp_valid_o;
   logic [NUM_REQ-1:0]      rsp_ready_i;
   logic [DW-1:0]           rsp_data_o;
   logic                    rsp_err_o;
   logic [DW-1:0]           ip_data_o;
   logic                    ip_enable_o;
   logic [DW-1:0]           ip_data_i;
   status_e                 ip_status_i;
   logic [1:0]              grant_id_o;
   logic                    busy_o;
   logic [7:0]              err_cnt_o;

   always #5 clk_i = ~clk_i;

   custom_axi_ip_sched #(
      .NUM_REQ        (NUM_REQ),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_ready_o (req_ready_o),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_data_o  (rsp_data_o),
      .rsp_err_o   (rsp_err_o),
      .ip_data_o   (ip_data_o),
      .ip_enable_o (ip_enable_o),
      .ip_data_i   (ip_data_i),
      .ip_status_i (ip_status_i),
      .grant_id_o  (grant_id_o),
      .busy_o      (busy_o),
      .err_cnt_o   (err_cnt_o)
   );

   // IP model: 0 = conforming (result = data+1), 1 = ERROR after BUSY, 2 = stuck BUSY.
   status_e       ip_st;
   logic [DW-1:0] ip_cap;
   logic [DW-1:0] ip_res;
   int            ip_mode = 0;
   logic          ip_clear = 1'b0;

   assign ip_status_i = ip_st;
   assign ip_data_i   = ip_res;

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ip_st  <= IDLE;
         ip_cap <= '0;
         ip_res <= '0;
      end else if (ip_clear) begin
         ip_st <= IDLE;
      end else begin
         case (ip_st)
            IDLE: if (ip_enable_o) begin
               ip_st  <= BUSY;
               ip_cap <= ip_data_o;
            end
            BUSY: begin
               if (ip_mode == 0) begin
                  ip_st  <= DONE;
                  ip_res <= ip_cap + 32'd1;
               end else if (ip_mode == 1) begin
                  ip_st <= ERROR;
               end
            end
            default: ip_st <= IDLE;
         endcase
      end
   end

   int                 n_checks = 0;
   int                 n_errors = 0;
   logic [NUM_REQ-1:0] pend = '0;
   logic [DW-1:0]      drv_data [NUM_REQ];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply();
      req_valid_i = pend;
      for (int i = 0; i < NUM_REQ; i++) req_data_i[i*DW +: DW] = drv_data[i];
   endtask

   task automatic add_req(input int i, input logic [DW-1:0] d);
      pend[i]     = 1'b1;
      drv_data[i] = d;
   endtask

   // Runs one job from S_IDLE through the response handshake.
   task automatic do_job(input int mode, input int delay, output int id,
                         output logic [DW-1:0] data, output logic err,
                         output int lat, output logic [7:0] cnt);
      int                 waitc;
      logic [NUM_REQ-1:0] gr;
      id  = -1;
      rsp_ready_i = (delay == 0) ? '1 : '0;
      apply();
      #1;
      waitc = 0;
      while (req_ready_o == '0 && waitc < 20) begin
         tick();
         waitc++;
      end
      chk("accept_seen", 64'(req_ready_o != '0), 64'd1);
      chk("ready_onehot", 64'($countones(req_ready_o)), 64'd1);
      gr = req_ready_o;
      for (int i = 0; i < NUM_REQ; i++) if (gr[i]) id = i;
      ip_mode = mode;
      tick();
      pend = pend & ~gr;
      apply();
      lat = 1;
      chk("launch_enable", 64'(ip_enable_o), 64'd1);
      chk("launch_busy", 64'(busy_o), 64'd1);
      chk("launch_grant_id", 64'(grant_id_o), 64'(id));
      chk("launch_ip_data", 64'(ip_data_o), 64'(drv_data[id]));
      while (rsp_valid_o == '0 && lat < TO + 10) begin
         tick();
         lat++;
         if (lat == 3 && rsp_valid_o == '0) chk("wait_enable_low", 64'(ip_enable_o), 64'd0);
         if (lat == 2) chk("no_accept_busy", 64'(req_ready_o), 64'd0);
      end
      chk("rsp_owner", 64'(rsp_valid_o), 64'(gr));
      chk("rsp_grant_id", 64'(grant_id_o), 64'(id));
      data = rsp_data_o;
      err  = rsp_err_o;
      if (delay > 0) begin
         rsp_ready_i = ~gr;  // non-owners ready: must be ignored
         for (int k = 0; k < delay; k++) begin
            tick();
            chk("hold_valid", 64'(rsp_valid_o), 64'(gr));
            chk("hold_data", {31'd0, rsp_err_o, rsp_data_o}, {31'd0, err, data});
            chk("hold_no_accept", 64'(req_ready_o), 64'd0);
         end
         rsp_ready_i = '1;
      end
      ip_clear = 1'b1;
      tick();
      ip_clear = 1'b0;
      chk("rsp_dropped", 64'(rsp_valid_o), 64'd0);
      chk("idle_after", 64'(busy_o), 64'd0);
      cnt = err_cnt_o;
      rsp_ready_i = '0;
   endtask

   typedef struct {
      logic [3:0]  add;
      int          mode;
      int          delay;
      int          exp_id;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_lat;
      logic [7:0]  exp_cnt;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int            id, lat, win, mode, delay;
      logic [DW-1:0] data, edata;
      logic          err;
      logic [7:0]    cnt;
      int            ptr_m, cnt_m;
      logic [3:0]    addm;

      // Requester i always offers 0x10*(i+1) in the table rows.
      vecs[0]  = '{4'b0001, 0, 0, 0, 32'h11, 1'b0, 4,  8'd0};
      vecs[1]  = '{4'b1111, 0, 1, 1, 32'h21, 1'b0, 4,  8'd0};
      vecs[2]  = '{4'b0000, 0, 0, 2, 32'h31, 1'b0, 4,  8'd0};
      vecs[3]  = '{4'b0000, 0, 2, 3, 32'h41, 1'b0, 4,  8'd0};
      vecs[4]  = '{4'b0000, 0, 0, 0, 32'h11, 1'b0, 4,  8'd0};
      vecs[5]  = '{4'b1010, 0, 0, 1, 32'h21, 1'b0, 4,  8'd0};
      vecs[6]  = '{4'b0000, 0, 0, 3, 32'h41, 1'b0, 4,  8'd0};
      vecs[7]  = '{4'b0100, 1, 0, 2, 32'h00, 1'b1, 4,  8'd1};
      vecs[8]  = '{4'b0001, 0, 0, 0, 32'h11, 1'b0, 4,  8'd1};
      vecs[9]  = '{4'b0010, 2, 0, 1, 32'h00, 1'b1, 17, 8'd2};
      vecs[10] = '{4'b0011, 0, 0, 0, 32'h11, 1'b0, 4,  8'd2};
      vecs[11] = '{4'b0000, 0, 1, 1, 32'h21, 1'b0, 4,  8'd2};

      for (int i = 0; i < NUM_REQ; i++) drv_data[i] = '0;
      rsp_ready_i = '0;
      apply();
      tick();
      tick();
      chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk("reset_busy", 64'(busy_o), 64'd0);
      rst_ni = 1'b1;
      tick();
      chk("post_reset_ready", 64'(req_ready_o), 64'd0);
      chk("post_reset_enable", 64'(ip_enable_o), 64'd0);
      chk("post_reset_outs", {rsp_err_o, rsp_data_o, ip_data_o, grant_id_o, err_cnt_o}, 64'd0);

      // Table-driven jobs
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < NUM_REQ; i++)
            if (vecs[r].add[i]) add_req(i, DW'(32'h10 * (i + 1)));
         do_job(vecs[r].mode, vecs[r].delay, id, data, err, lat, cnt);
         chk("tbl_id", 64'(id), 64'(vecs[r].exp_id));
         chk("tbl_data", 64'(data), 64'(vecs[r].exp_data));
         chk("tbl_err", 64'(err), 64'(vecs[r].exp_err));
         chk("tbl_latency", 64'(lat), 64'(vecs[r].exp_lat));
         chk("tbl_err_cnt", 64'(cnt), 64'(vecs[r].exp_cnt));
      end

      // Owner holds rsp_ready low for 5 cycles while req0 waits (ptr is 2).
      add_req(0, 32'h10);
      add_req(2, 32'h30);
      do_job(0, 5, id, data, err, lat, cnt);
      chk("bp_id", 64'(id), 64'd2);
      chk("bp_data", 64'(data), 64'h31);
      do_job(0, 0, id, data, err, lat, cnt);
      chk("bp_next_id", 64'(id), 64'd0);

      // Reset while in S_WAIT: job dropped, pointer back to 0.
      add_req(1, 32'h20);
      apply();
      #1;
      chk("rst_accept", 64'(req_ready_o), 64'b0010);
      ip_mode = 0;
      tick();
      pend = '0;
      apply();
      tick();
      tick();
      chk("rst_pre_busy", 64'(busy_o), 64'd1);
      chk("rst_pre_wait", 64'(ip_enable_o), 64'd0);
      rst_ni = 1'b0;
      #1;
      chk("rst_ready", 64'(req_ready_o), 64'd0);
      chk("rst_valid", 64'(rsp_valid_o), 64'd0);
      chk("rst_enable", 64'(ip_enable_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_outs", {rsp_err_o, rsp_data_o, ip_data_o, grant_id_o, err_cnt_o}, 64'd0);
      tick();
      tick();
      rst_ni = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_no_rsp", 64'(rsp_valid_o), 64'd0);
      end
      add_req(0, 32'h10);
      add_req(1, 32'h20);
      do_job(0, 0, id, data, err, lat, cnt);
      chk("rst_ptr0_wins", 64'(id), 64'd0);
      do_job(0, 0, id, data, err, lat, cnt);
      chk("rst_then_req1", 64'(id), 64'd1);
      chk("rst_cnt_cleared", 64'(cnt), 64'd0);

      // Randomized jobs vs. transaction-level model
      ptr_m = 2;
      cnt_m = 0;
      for (int it = 0; it < 60; it++) begin
         addm = 4'($urandom) & ~pend;
         if ((pend | addm) == 4'b0000) addm = 4'b0001 << $urandom_range(0, 3);
         for (int i = 0; i < NUM_REQ; i++) if (addm[i]) add_req(i, DW'($urandom));
         win = -1;
         for (int k = 0; k < NUM_REQ; k++)
            if (win < 0 && pend[(ptr_m + k) % NUM_REQ]) win = (ptr_m + k) % NUM_REQ;
         mode  = $urandom_range(0, 9);
         mode  = (mode < 6) ? 0 : (mode < 9) ? 1 : 2;
         delay = $urandom_range(0, 3);
         edata = (mode == 0) ? drv_data[win] + 32'd1 : 32'd0;
         do_job(mode, delay, id, data, err, lat, cnt);
         if (mode != 0 && cnt_m < 255) cnt_m++;
         chk("rnd_id", 64'(id), 64'(win));
         chk("rnd_data", 64'(data), 64'(edata));
         chk("rnd_err", 64'(err), 64'(mode != 0));
         chk("rnd_latency", 64'(lat), 64'((mode == 2) ? TO + 1 : 4));
         chk("rnd_err_cnt", 64'(cnt), 64'(cnt_m));
         ptr_m = (win + 1) % NUM_REQ;
      end

      // Error counter saturation
      for (int k = 0; k < 260; k++) begin
         add_req(k % NUM_REQ, DW'(k));
         do_job(1, 0, id, data, err, lat, cnt);
         if (cnt_m < 255) cnt_m++;
         chk("sat_err_cnt", 64'(cnt), 64'(cnt_m));
      end
      chk("err_cnt_saturated", 64'(err_cnt_o), 64'hFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=running expected=finished");
      $fatal(1);
   end

endmodule
